// File: rtl/gray_step_decoder.sv
// rtl/gray_step_decoder.sv - Registered Gray-to-binary decoder with single-step motion tracking (option: GRAY_STEP_ERRCNT_EN)
module gray_step_decoder #(
    parameter int W     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     g_in,
    input  logic             in_valid,
    input  logic             clr_err,
    output logic [W-1:0]     b_out,
    output logic             out_valid,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic [CNT_W-1:0] pos
`ifdef GRAY_STEP_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [W-1:0]     D_UP    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     D_DOWN  = {W{1'b1}};
    localparam logic [CNT_W-1:0] POS_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t       state;
    logic [W-1:0] pb;
    logic [W-1:0] nb;
    logic [W-1:0] d;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        nb = gray2bin(g_in);
        d  = nb - pb;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pb        <= '0;
            b_out     <= '0;
            out_valid <= 1'b0;
            step      <= 1'b0;
            dir       <= 1'b1;
            err       <= 1'b0;
            pos       <= '0;
`ifdef GRAY_STEP_ERRCNT_EN
            err_cnt   <= 8'd0;
`endif
        end else begin
            out_valid <= 1'b0;
            step      <= 1'b0;
            if (state == FAULT && clr_err) begin
                // A sample arriving with the clear is taken as the resync sample.
                err <= 1'b0;
                if (in_valid) begin
                    b_out     <= nb;
                    pb        <= nb;
                    out_valid <= 1'b1;
                    state     <= TRACK;
                end else begin
                    state <= IDLE;
                end
            end else if (in_valid) begin
                b_out     <= nb;
                pb        <= nb;
                out_valid <= 1'b1;
                case (state)
                    IDLE: state <= TRACK;
                    TRACK: begin
                        if (d == D_UP) begin
                            step <= 1'b1;
                            dir  <= 1'b1;
                            pos  <= pos + POS_ONE;
                        end else if (d == D_DOWN) begin
                            step <= 1'b1;
                            dir  <= 1'b0;
                            pos  <= pos - POS_ONE;
                        end else if (d != '0) begin
                            err   <= 1'b1;
                            state <= FAULT;
`ifdef GRAY_STEP_ERRCNT_EN
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
`endif
                        end
                    end
                    default: state <= FAULT;
                endcase
            end
        end
    end

endmodule
